// File: rtl/config_read_demux_if.sv
// Config read channel: one request/response pair between a bridge and a register.
// The m side issues reads; the s side serves them.
interface read_config_i #(
   parameter int AXIL_ADDR_BITS = 32,
   parameter int AXIL_DATA_BITS = 32
);
   logic                      read_valid;
   logic                      read_ready;
   logic [AXIL_ADDR_BITS-1:0] read_addr;
   logic                      resp_valid;
   logic                      resp_ready;
   logic [AXIL_DATA_BITS-1:0] resp_data;
   logic                      resp_error;

   modport m (
      output read_valid, read_addr, resp_ready,
      input  read_ready, resp_valid, resp_data, resp_error
   );

   modport s (
      input  read_valid, read_addr, resp_ready,
      output read_ready, resp_valid, resp_data, resp_error
   );
endinterface

// File: rtl/config_read_demux.sv
// Routes one upstream config read at a time to the addressed register and returns
// its response, or an error for unmapped addresses and registers that never answer.
module config_read_demux #(
   parameter int          NUM_REGS       = 4,
   parameter int unsigned BASE_ADDR      = 0,
   parameter int          ADDR_STRIDE    = 4,
   parameter int          TIMEOUT_CYCLES = 256,
   parameter int          AXIL_ADDR_BITS = 32,
   parameter int          AXIL_DATA_BITS = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   read_config_i.s        conf,
   read_config_i.m        regs [NUM_REGS]
);

   localparam int SEL_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam int STRIDE_SH = $clog2(ADDR_STRIDE);

   localparam logic [AXIL_ADDR_BITS-1:0] BASE   = AXIL_ADDR_BITS'(BASE_ADDR);
   localparam logic [AXIL_ADDR_BITS-1:0] SPAN   = AXIL_ADDR_BITS'(NUM_REGS * ADDR_STRIDE);
   localparam logic [AXIL_ADDR_BITS-1:0] S_MASK = AXIL_ADDR_BITS'(ADDR_STRIDE - 1);
   localparam logic [CNT_W-1:0]          CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_RESP = 2'd2,
      RESPOND   = 2'd3
   } state_t;

   state_t                    state;
   logic [SEL_W-1:0]          sel;
   logic [AXIL_ADDR_BITS-1:0] addr_q;
   logic [AXIL_DATA_BITS-1:0] data_q;
   logic                      err_q;
   logic [CNT_W-1:0]          cnt;

   logic [AXIL_ADDR_BITS-1:0] off;
   logic                      hit;
   logic [SEL_W-1:0]          idx;

   logic [NUM_REGS-1:0]       rd_ready_vec;
   logic [NUM_REGS-1:0]       rsp_valid_vec;
   logic [NUM_REGS-1:0]       rsp_error_vec;
   logic [AXIL_DATA_BITS-1:0] rsp_data_arr [NUM_REGS];

   logic                      sel_read_ready;
   logic                      sel_resp_valid;
   logic                      sel_resp_error;
   logic [AXIL_DATA_BITS-1:0] sel_resp_data;
   logic                      timed_out;

   // Addresses below BASE wrap to a huge offset and fall outside SPAN.
   assign off = conf.read_addr - BASE;
   assign hit = (off < SPAN) && ((off & S_MASK) == '0);
   assign idx = SEL_W'(off >> STRIDE_SH);

   assign conf.read_ready = (state == IDLE);
   assign conf.resp_valid = (state == RESPOND);
   assign conf.resp_data  = data_q;
   assign conf.resp_error = err_q;

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_port
      assign regs[i].read_valid = (state == ISSUE) && (sel == SEL_W'(i));
      assign regs[i].read_addr  = addr_q;
      // IDLE keeps every port draining so late answers from a timed-out register vanish.
      assign regs[i].resp_ready = (state == IDLE) ||
                                  ((state == WAIT_RESP) && (sel == SEL_W'(i)));
      assign rd_ready_vec[i]    = regs[i].read_ready;
      assign rsp_valid_vec[i]   = regs[i].resp_valid;
      assign rsp_error_vec[i]   = regs[i].resp_error;
      assign rsp_data_arr[i]    = regs[i].resp_data;
   end

   assign sel_read_ready = rd_ready_vec[sel];
   assign sel_resp_valid = rsp_valid_vec[sel];
   assign sel_resp_error = rsp_error_vec[sel];
   assign sel_resp_data  = rsp_data_arr[sel];
   assign timed_out      = (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         sel    <= '0;
         addr_q <= '0;
         data_q <= '0;
         err_q  <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (conf.read_valid) begin
                  addr_q <= conf.read_addr;
                  if (hit) begin
                     sel   <= idx;
                     cnt   <= '0;
                     state <= ISSUE;
                  end else begin
                     data_q <= '0;
                     err_q  <= 1'b1;
                     state  <= RESPOND;
                  end
               end
            end
            ISSUE: begin
               cnt <= cnt + CNT_W'(1);
               if (sel_read_ready) begin
                  state <= WAIT_RESP;
               end else if (timed_out) begin
                  data_q <= '0;
                  err_q  <= 1'b1;
                  state  <= RESPOND;
               end
            end
            WAIT_RESP: begin
               cnt <= cnt + CNT_W'(1);
               if (sel_resp_valid) begin
                  data_q <= sel_resp_data;
                  err_q  <= sel_resp_error;
                  state  <= RESPOND;
               end else if (timed_out) begin
                  data_q <= '0;
                  err_q  <= 1'b1;
                  state  <= RESPOND;
               end
            end
            RESPOND: begin
               if (conf.resp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
